// File: rtl/wb_arbiter_2m.sv
// Two-master Wishbone arbiter (instruction m0, data m1) onto one shared slave port.
// Optional stalled-strobe watchdog is compiled in with `define WB_ARB_TIMEOUT_EN.
module wb_arbiter_2m #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] m0_addr_i,
    input  logic [31:0] m0_data_i,
    input  logic        m0_we_i,
    input  logic [3:0]  m0_sel_i,
    input  logic        m0_stb_i,
    input  logic        m0_cyc_i,
    output logic [31:0] m0_data_o,
    output logic        m0_ack_o,
    input  logic [31:0] m1_addr_i,
    input  logic [31:0] m1_data_i,
    input  logic        m1_we_i,
    input  logic [3:0]  m1_sel_i,
    input  logic        m1_stb_i,
    input  logic        m1_cyc_i,
    output logic [31:0] m1_data_o,
    output logic        m1_ack_o,
    output logic [31:0] s_addr_o,
    output logic [31:0] s_data_o,
    output logic        s_we_o,
    output logic [3:0]  s_sel_o,
    output logic        s_stb_o,
    output logic        s_cyc_o,
    input  logic [31:0] s_data_i,
    input  logic        s_ack_i,
    output logic [1:0]  gnt_o,
    output logic        timeout_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        GNT_M0 = 2'b01,
        GNT_M1 = 2'b10
    } state_t;

    state_t state_r;
    state_t next_state_s;
    logic   last_gnt_r;     // 1'b0 = m0 won the latest grant, 1'b1 = m1
    logic   req0_s;
    logic   req1_s;
    logic   timeout_hit_s;

    assign req0_s = m0_cyc_i & m0_stb_i;
    assign req1_s = m1_cyc_i & m1_stb_i;

    if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
        $error("wb_arbiter_2m: TIMEOUT_CYCLES must be nonzero");
    end

    // State register and round-robin history, updated when a grant is taken
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            last_gnt_r <= 1'b0;
        end else begin
            state_r <= next_state_s;
            if ((state_r == IDLE) && (next_state_s != IDLE)) begin
                last_gnt_r <= (next_state_s == GNT_M1);
            end
        end
    end

    // Next-state logic; every handover goes back through IDLE for turnaround
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (req0_s && req1_s) begin
                    next_state_s = last_gnt_r ? GNT_M0 : GNT_M1;
                end else if (req0_s) begin
                    next_state_s = GNT_M0;
                end else if (req1_s) begin
                    next_state_s = GNT_M1;
                end else begin
                    next_state_s = IDLE;
                end
            end
            GNT_M0: begin
                if (timeout_hit_s || !m0_cyc_i) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = GNT_M0;
                end
            end
            GNT_M1: begin
                if (timeout_hit_s || !m1_cyc_i) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = GNT_M1;
                end
            end
            default: next_state_s = IDLE;
        endcase
    end

`ifdef WB_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES < 32'd256) ? 8 : $clog2(TIMEOUT_CYCLES + 32'd1);
    localparam logic [CNT_W-1:0] TIMEOUT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] stall_cnt_r;

    // Stall counter: counts unacknowledged strobe cycles of the current grant
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_r <= '0;
        end else if ((next_state_s == IDLE) || s_ack_i) begin
            stall_cnt_r <= '0;
        end else if ((state_r != IDLE) && s_stb_o) begin
            stall_cnt_r <= stall_cnt_r + CNT_W'(1);
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign timeout_hit_s = (state_r != IDLE) && (stall_cnt_r == TIMEOUT_LIMIT);
`else
    assign timeout_hit_s = 1'b0;
`endif

    // Output routing: slave side follows the granted master, a forced
    // termination drops cyc/stb and hands the master an empty ack
    always_comb begin
        s_addr_o  = 32'h0;
        s_data_o  = 32'h0;
        s_we_o    = 1'b0;
        s_sel_o   = 4'h0;
        s_stb_o   = 1'b0;
        s_cyc_o   = 1'b0;
        m0_ack_o  = 1'b0;
        m0_data_o = 32'h0;
        m1_ack_o  = 1'b0;
        m1_data_o = 32'h0;
        gnt_o     = 2'b00;
        case (state_r)
            IDLE: begin
                gnt_o = 2'b00;
            end
            GNT_M0: begin
                s_addr_o  = m0_addr_i;
                s_data_o  = m0_data_i;
                s_we_o    = m0_we_i;
                s_sel_o   = m0_sel_i;
                s_stb_o   = m0_stb_i & ~timeout_hit_s;
                s_cyc_o   = m0_cyc_i & ~timeout_hit_s;
                m0_ack_o  = s_ack_i | timeout_hit_s;
                m0_data_o = timeout_hit_s ? 32'h0 : s_data_i;
                gnt_o     = 2'b01;
            end
            GNT_M1: begin
                s_addr_o  = m1_addr_i;
                s_data_o  = m1_data_i;
                s_we_o    = m1_we_i;
                s_sel_o   = m1_sel_i;
                s_stb_o   = m1_stb_i & ~timeout_hit_s;
                s_cyc_o   = m1_cyc_i & ~timeout_hit_s;
                m1_ack_o  = s_ack_i | timeout_hit_s;
                m1_data_o = timeout_hit_s ? 32'h0 : s_data_i;
                gnt_o     = 2'b10;
            end
            default: begin
                gnt_o = 2'b00;
            end
        endcase
        timeout_o = timeout_hit_s;
    end

endmodule
